operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 138 +++++++++++++
 tb/tb_operand_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// operand_loader: collects a batch of DEPTH A/B operand pairs from a
// valid/ready word stream, pulses start when the batch is full, then holds
// the operands for the processing datapath until proc_done.
// Optional feature macro: LOADER_CHECKSUM_EN adds an XOR checksum output
// covering every word accepted in the current batch.
module operand_loader #(
   parameter int unsigned N     = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    read_addr,
   output logic [N-1:0]  outA,
   output logic [N-1:0]  outB,
   output logic          start,
   input  logic          proc_done,
   output logic [3:0]    fill_count
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [N-1:0]  checksum
`endif
);

   localparam int unsigned AW = 3;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;

   logic [AW-1:0]  wr_ptr;
   logic           phase_b;
   logic [CW-1:0]  fill_q;
   logic [N-1:0]   mem_a [DEPTH];
   logic [N-1:0]   mem_b [DEPTH];

   logic           accept;
   logic           last_word;
   logic           clear_batch;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode; ready depends only on state and reset
   always_comb begin
      state_next  = state;
      in_ready    = 1'b0;
      start       = 1'b0;
      accept      = 1'b0;
      last_word   = 1'b0;
      clear_batch = 1'b0;
      case (state)
         LOAD: begin
            in_ready  = ~rst;
            accept    = in_valid & ~rst;
            last_word = phase_b && (wr_ptr == AW'(DEPTH - 1));
            if (accept && last_word) begin
               state_next = START;
            end
         end
         START: begin
            start      = 1'b1;
            state_next = HOLD;
         end
         HOLD: begin
            if (proc_done) begin
               clear_batch = 1'b1;
               state_next  = LOAD;
            end
         end
         default: begin
            state_next = LOAD;
         end
      endcase
   end

   // Operand storage, write pointer, A/B phase and pair counter
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         phase_b <= 1'b0;
         fill_q  <= '0;
         mem_a   <= '{default: '0};
         mem_b   <= '{default: '0};
      end else if (clear_batch) begin
         wr_ptr  <= '0;
         phase_b <= 1'b0;
         fill_q  <= '0;
      end else if (accept) begin
         if (!phase_b) begin
            mem_a[wr_ptr] <= in_data;
         end else begin
            mem_b[wr_ptr] <= in_data;
            wr_ptr        <= wr_ptr + AW'(1);
            fill_q        <= fill_q + CW'(1);
         end
         phase_b <= ~phase_b;
      end
   end

   assign fill_count = fill_q;

   // Combinational read port for the processing datapath
   assign outA = mem_a[read_addr];
   assign outB = mem_b[read_addr];

`ifdef LOADER_CHECKSUM_EN
   logic [N-1:0] csum_q;

   // Running XOR of accepted words; frozen outside LOAD since nothing is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q <= '0;
      end else if (clear_batch) begin
         csum_q <= '0;
      end else if (accept) begin
         csum_q <= csum_q ^ in_data;
      end
   end

   assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader.
// Build with LOADER_CHECKSUM_EN defined to exercise the checksum output.
module tb_operand_loader;

   logic        clk;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  read_addr;
   logic [15:0] outA;
   logic [15:0] outB;
   logic        start;
   logic        proc_done;
   logic [3:0]  fill_count;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int checks;
   int errors;
   int start_cnt;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  fill;
   } wr_vec_t;

   typedef struct {
      logic [2:0]  addr;
      logic [15:0] a;
      logic [15:0] b;
   } rd_vec_t;

   wr_vec_t stream_tbl [16];
   rd_vec_t read_tbl [8];
   wr_vec_t batch [16];

   operand_loader #(.N(16), .DEPTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .read_addr  (read_addr),
      .outA       (outA),
      .outB       (outB),
      .start      (start),
      .proc_done  (proc_done),
      .fill_count (fill_count)
`ifdef LOADER_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count start pulses away from the active edge
   always @(negedge clk) begin
      if (start) start_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read_check(input logic [2:0] addr, input logic [15:0] ea, input logic [15:0] eb);
      read_addr = addr;
      #1;
      check($sformatf("outA[%0d]", addr), 32'(outA), 32'(ea));
      check($sformatf("outB[%0d]", addr), 32'(outB), 32'(eb));
   endtask

   task automatic push(input logic [15:0] w);
      int t;
      t = 0;
      in_data  = w;
      in_valid = 1'b1;
      while (!in_ready && t < 50) begin
         step();
         t++;
      end
      if (!in_ready) check("push_wait_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      rst       = 1'b1;
      in_valid  = 1'b0;
      proc_done = 1'b0;
      #1;
      check("ready_during_rst", 32'(in_ready), 32'd0);
      repeat (cycles) step();
      check("start_after_rst", 32'(start), 32'd0);
      check("fill_after_rst", 32'(fill_count), 32'd0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(in_ready), 32'd1);
   endtask

   task automatic release_hold();
      proc_done = 1'b1;
      step();
      proc_done = 1'b0;
      check("ready_after_done", 32'(in_ready), 32'd1);
      check("fill_after_done", 32'(fill_count), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      check("csum_after_done", 32'(checksum), 32'd0);
`endif
   endtask

   task automatic make_batch(input logic [15:0] base);
      for (int k = 0; k < 16; k++) begin
         batch[k].data = base + 16'(k);
         batch[k].fill = 4'((k + 1) / 2);
      end
   endtask

   task automatic load_batch(input wr_vec_t v [16], input bit gaps);
      int          base_cnt;
      logic [15:0] x;
      base_cnt = start_cnt;
      x = '0;
      for (int k = 0; k < 16; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               in_valid = 1'b0;
               in_data  = 16'hDEAD;
               step();
            end
         end
         push(v[k].data);
         x ^= v[k].data;
         check($sformatf("fill_after_word%0d", k), 32'(fill_count), 32'(v[k].fill));
         if (k == 0) begin
            read_addr = 3'd0;
            #1;
            check("first_write_visible", 32'(outA), 32'(v[0].data));
         end
         if (k < 15) check("start_early", 32'(start), 32'd0);
      end
      check("start_pulse", 32'(start), 32'd1);
      check("ready_in_start", 32'(in_ready), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      check("csum_at_start", 32'(checksum), 32'(x));
`endif
      step();
      check("start_one_cycle", 32'(start), 32'd0);
      check("ready_in_hold", 32'(in_ready), 32'd0);
      check("start_count", 32'(start_cnt - base_cnt), 32'd1);
   endtask

   task automatic readback_seq(input logic [15:0] base);
      for (int i = 0; i < 8; i++) begin
         read_check(3'(i), base + 16'(2 * i), base + 16'(2 * i + 1));
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      start_cnt = 0;
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      proc_done = 1'b0;
      read_addr = '0;

      for (int k = 0; k < 16; k += 2) begin
         stream_tbl[k]     = '{16'(k + 1), 4'(k / 2)};
         stream_tbl[k + 1] = '{16'(k + 2), 4'(k / 2 + 1)};
      end
      read_tbl[0] = '{3'd0, 16'h0001, 16'h0002};
      read_tbl[1] = '{3'd1, 16'h0003, 16'h0004};
      read_tbl[2] = '{3'd2, 16'h0005, 16'h0006};
      read_tbl[3] = '{3'd3, 16'h0007, 16'h0008};
      read_tbl[4] = '{3'd4, 16'h0009, 16'h000A};
      read_tbl[5] = '{3'd5, 16'h000B, 16'h000C};
      read_tbl[6] = '{3'd6, 16'h000D, 16'h000E};
      read_tbl[7] = '{3'd7, 16'h000F, 16'h0010};

      step();
      do_reset(2);
      read_check(3'd0, 16'h0000, 16'h0000);
      read_check(3'd7, 16'h0000, 16'h0000);

      // Full batch streamed back to back
      load_batch(stream_tbl, 1'b0);
      for (int i = 0; i < 8; i++) read_check(read_tbl[i].addr, read_tbl[i].a, read_tbl[i].b);

      // Words offered in HOLD are not consumed
      for (int c = 0; c < 5; c++) begin
         in_data  = 16'hFFFF;
         in_valid = 1'b1;
         check("ready_hold_valid", 32'(in_ready), 32'd0);
         step();
      end
      in_valid = 1'b0;
      check("hold_fill", 32'(fill_count), 32'd8);
      check("hold_no_start", 32'(start_cnt), 32'd1);
      for (int i = 0; i < 8; i++) read_check(read_tbl[i].addr, read_tbl[i].a, read_tbl[i].b);
      release_hold();
      read_check(3'd0, 16'h0001, 16'h0002);

      // proc_done during LOAD is ignored
      make_batch(16'h0100);
      for (int k = 0; k < 4; k++) push(batch[k].data);
      proc_done = 1'b1;
      step();
      step();
      proc_done = 1'b0;
      check("load_done_fill", 32'(fill_count), 32'd2);
      check("load_done_ready", 32'(in_ready), 32'd1);
      for (int k = 4; k < 16; k++) begin
         push(batch[k].data);
         if (k < 15) check("load_done_no_start", 32'(start), 32'd0);
      end
      check("load_done_start", 32'(start), 32'd1);
      check("load_done_fill8", 32'(fill_count), 32'd8);
      step();
      check("load_done_count", 32'(start_cnt), 32'd2);
      readback_seq(16'h0100);
      release_hold();

      // Randomly gapped valid
      make_batch(16'h0200);
      load_batch(batch, 1'b1);
      readback_seq(16'h0200);
      release_hold();

      // Reset in the middle of a batch
      make_batch(16'h0300);
      for (int k = 0; k < 7; k++) push(batch[k].data);
      check("mid_fill", 32'(fill_count), 32'd3);
      do_reset(1);
      for (int i = 0; i < 8; i++) read_check(3'(i), 16'h0000, 16'h0000);
      repeat (4) step();
      check("mid_rst_no_start", 32'(start_cnt), 32'd3);
      make_batch(16'h0400);
      load_batch(batch, 1'b0);
      readback_seq(16'h0400);
      release_hold();

`ifdef LOADER_CHECKSUM_EN
      for (int k = 0; k < 16; k++) batch[k] = '{16'h0000, 4'((k + 1) / 2)};
      batch[0].data = 16'h1234;
      batch[1].data = 16'h00FF;
      load_batch(batch, 1'b0);
      check("csum_hold", 32'(checksum), 32'h12CB);
      release_hold();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
